// File: rtl/sgd_mtm_optim.sv
// ---------------------------------------------------------------------------
// sgd_mtm_optim -- SGD-with-momentum weight updater.
//
// Streams DEPTH beats of (w, v, grad) from external memories, computes per
// lane
//   v' = momentum*v - lr*g   (fixed point, F_LEN fraction bits)
//   w' = w + v'
// and writes w', v' back. A beat issued on raddr=a at cycle t appears on
// we/waddr/wdata at cycle t+3 (1 cycle memory read + 2 pipeline stages).
//
// Configuration macro: OPTIM_SAT_EN
//   defined   -> mm, ml, v', w' saturate to the signed N_LEN range
//   undefined -> all arithmetic wraps modulo 2^N_LEN
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               level request: high starts/holds a pass, low aborts
//   momentum, lr      signed coefficients, latched when a pass starts
//   raddr             read address for the w, v and grad memories
//   rdata_w/v/grad    read data, valid one cycle after raddr
//   we, waddr         write strobe/address for the w and v memories
//   wdata_w, wdata_v  updated weight and velocity
//   busy              high while reading or draining
//   valid             high once the pass has completed (state DONE)
// Lane i of every data bus sits at bits [i*N_LEN +: N_LEN].
// ---------------------------------------------------------------------------
module sgd_mtm_optim #(
  parameter int DATA_N     = 4,
  parameter int N_LEN      = 16,
  parameter int F_LEN      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [N_LEN-1:0]          momentum,
  input  logic [N_LEN-1:0]          lr,
  output logic [ADDR_WIDTH-1:0]     raddr,
  input  logic [DATA_N*N_LEN-1:0]   rdata_w,
  input  logic [DATA_N*N_LEN-1:0]   rdata_v,
  input  logic [DATA_N*N_LEN-1:0]   rdata_grad,
  output logic                      we,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic [DATA_N*N_LEN-1:0]   wdata_w,
  output logic [DATA_N*N_LEN-1:0]   wdata_v,
  output logic                      busy,
  output logic                      valid
);

  localparam int LW = DATA_N * N_LEN;
  localparam int PW = 2 * N_LEN;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  logic [N_LEN-1:0]        mom_q, lr_q;

  // Beat whose memory data is on rdata_* this cycle.
  logic                    rd_vld;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // Stage 1: scaled terms and delayed weight.
  logic                    s1_vld;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [LW-1:0]           mm_q, ml_q, w_q;

  logic [LW-1:0]           mm_nx, ml_nx, v_nx, w_nx;

  // ------------------------------------------------------------------------
  // Arithmetic helpers
  // ------------------------------------------------------------------------
  function automatic logic [PW-1:0] sext(input logic [N_LEN-1:0] x);
    return {{N_LEN{x[N_LEN-1]}}, x};
  endfunction

`ifdef OPTIM_SAT_EN
  // Clamp a sign-extended value to the signed N_LEN range.
  function automatic logic [N_LEN-1:0] clamp(input logic [PW-1:0] x);
    if ((&x[PW-1:N_LEN-1]) || !(|x[PW-1:N_LEN-1]))
      return x[N_LEN-1:0];
    return x[PW-1] ? {1'b1, {(N_LEN-1){1'b0}}} : {1'b0, {(N_LEN-1){1'b1}}};
  endfunction
`endif

  // Fixed-point scale: full signed product, take [F_LEN +: N_LEN].
  // Dropping low bits of a two's-complement value truncates toward -inf.
  function automatic logic [N_LEN-1:0] scale(input logic [N_LEN-1:0] c,
                                             input logic [N_LEN-1:0] x);
    logic [PW-1:0] p;
    // Low PW bits of the product of sign-extended operands equal the
    // signed product, so an unsigned multiply is sufficient here.
    p = sext(c) * sext(x);
`ifdef OPTIM_SAT_EN
    return clamp({{F_LEN{p[PW-1]}}, p[PW-1:F_LEN]});
`else
    return p[F_LEN +: N_LEN];
`endif
  endfunction

  function automatic logic [N_LEN-1:0] sub_n(input logic [N_LEN-1:0] a,
                                             input logic [N_LEN-1:0] b);
`ifdef OPTIM_SAT_EN
    return clamp(sext(a) - sext(b));
`else
    return a - b;
`endif
  endfunction

  function automatic logic [N_LEN-1:0] add_n(input logic [N_LEN-1:0] a,
                                             input logic [N_LEN-1:0] b);
`ifdef OPTIM_SAT_EN
    return clamp(sext(a) + sext(b));
`else
    return a + b;
`endif
  endfunction

  // ------------------------------------------------------------------------
  // Per-lane datapath
  // ------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    mm_nx = '0;
    ml_nx = '0;
    v_nx  = '0;
    w_nx  = '0;
    for (int i = 0; i < DATA_N; i++) begin
      mm_nx[i*N_LEN +: N_LEN] = scale(mom_q, rdata_v[i*N_LEN +: N_LEN]);
      ml_nx[i*N_LEN +: N_LEN] = scale(lr_q,  rdata_grad[i*N_LEN +: N_LEN]);
      v_nx[i*N_LEN +: N_LEN]  = sub_n(mm_q[i*N_LEN +: N_LEN],
                                      ml_q[i*N_LEN +: N_LEN]);
      // w' adds the already-final (saturated if enabled) v'.
      w_nx[i*N_LEN +: N_LEN]  = add_n(w_q[i*N_LEN +: N_LEN],
                                      v_nx[i*N_LEN +: N_LEN]);
    end
  end

  // ------------------------------------------------------------------------
  // Control FSM, pipeline and registered outputs
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pipeline data registers are few and reset to zero so no
      // stale data from an earlier pass can be observed on wdata.
      state   <= IDLE;
      mom_q   <= '0;
      lr_q    <= '0;
      raddr   <= '0;
      rd_vld  <= 1'b0;
      rd_addr <= '0;
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      mm_q    <= '0;
      ml_q    <= '0;
      w_q     <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata_w <= '0;
      wdata_v <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      // Pipeline advance; beats are only issued while in READ.
      rd_vld  <= (state == READ);
      rd_addr <= raddr;
      s1_vld  <= rd_vld;
      we      <= s1_vld;
      if (rd_vld) begin
        s1_addr <= rd_addr;
        mm_q    <= mm_nx;
        ml_q    <= ml_nx;
        w_q     <= rdata_w;
      end
      if (s1_vld) begin
        waddr   <= s1_addr;
        wdata_v <= v_nx;
        wdata_w <= w_nx;
      end

      case (state)
        IDLE: begin
          if (run) begin
            state <= READ;
            raddr <= '0;
            mom_q <= momentum;
            lr_q  <= lr;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (raddr == LAST) state <= DRAIN;
          else               raddr <= raddr + ADDR_WIDTH'(1);
        end
        DRAIN: begin
          // The last beat is committed at the edge that ends its we cycle.
          if (we && waddr == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase

      // Dropping run outside IDLE aborts: flush in-flight beats, rewind.
      if (state != IDLE && !run) begin
        state  <= IDLE;
        raddr  <= '0;
        rd_vld <= 1'b0;
        s1_vld <= 1'b0;
        we     <= 1'b0;
        busy   <= 1'b0;
        valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sgd_mtm_optim.sv
// ---------------------------------------------------------------------------
// tb_sgd_mtm_optim -- directed self-checking bench for sgd_mtm_optim
// (DATA_N=4, N_LEN=16, F_LEN=8, DEPTH=8). A behavioural memory returns
// read data one cycle after raddr. Expected values are hand-computed
// Q8.8 constants. Honours OPTIM_SAT_EN for the overflow boundary vector.
// ---------------------------------------------------------------------------
module tb_sgd_mtm_optim;

  localparam int DATA_N = 4;
  localparam int N_LEN  = 16;
  localparam int F_LEN  = 8;
  localparam int DEPTH  = 8;
  localparam int AW     = 10;
  localparam int LW     = DATA_N * N_LEN;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [15:0]   momentum, lr;
  logic [AW-1:0] raddr, waddr;
  logic [LW-1:0] rdata_w, rdata_v, rdata_grad;
  logic          we, busy, valid;
  logic [LW-1:0] wdata_w, wdata_v;

  logic [LW-1:0] mem_w [DEPTH];
  logic [LW-1:0] mem_v [DEPTH];
  logic [LW-1:0] mem_g [DEPTH];
  logic [LW-1:0] exp_w [DEPTH];
  logic [LW-1:0] exp_v [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  sgd_mtm_optim #(
    .DATA_N(DATA_N), .N_LEN(N_LEN), .F_LEN(F_LEN),
    .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .momentum(momentum), .lr(lr),
    .raddr(raddr), .rdata_w(rdata_w), .rdata_v(rdata_v),
    .rdata_grad(rdata_grad), .we(we), .waddr(waddr),
    .wdata_w(wdata_w), .wdata_v(wdata_v), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  always @(posedge clk) begin
    rdata_w    <= mem_w[raddr[2:0]];
    rdata_v    <= mem_v[raddr[2:0]];
    rdata_grad <= mem_g[raddr[2:0]];
  end

  function automatic logic [LW-1:0] pack(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default beat: v=2.0, g=0, w=1.0.
  task automatic load_default();
    for (int a = 0; a < DEPTH; a++) begin
      mem_w[a] = pack(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      mem_v[a] = pack(16'h0200, 16'h0200, 16'h0200, 16'h0200);
      mem_g[a] = '0;
    end
  endtask

  task automatic set_exp_all(input logic [15:0] ev, input logic [15:0] ew);
    for (int a = 0; a < DEPTH; a++) begin
      exp_v[a] = pack(ev, ev, ev, ev);
      exp_w[a] = pack(ew, ew, ew, ew);
    end
  endtask

  // Full pass from IDLE; checks every cycle from the start edge to DONE.
  // With perturb set, the coefficient inputs change after the start edge
  // and must have no effect on the results.
  task automatic run_pass(input string tag, input bit perturb);
    run = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0 && perturb) begin
        momentum = 16'h7FFF;
        lr       = 16'h7FFF;
      end
      check($sformatf("%s_raddr_c%0d", tag, c), 64'(raddr),
            64'((c < DEPTH - 1) ? c : DEPTH - 1));
      check($sformatf("%s_we_c%0d", tag, c), 64'(we),
            64'(c >= 3 && c <= 10));
      check($sformatf("%s_busy_c%0d", tag, c), 64'(busy), 64'(c <= 10));
      check($sformatf("%s_valid_c%0d", tag, c), 64'(valid), 64'(c == 11));
      if (c >= 3 && c <= 10) begin
        check($sformatf("%s_waddr_c%0d", tag, c), 64'(waddr), 64'(c - 3));
        check($sformatf("%s_wv_a%0d", tag, c - 3), wdata_v, exp_v[c - 3]);
        check($sformatf("%s_ww_a%0d", tag, c - 3), wdata_w, exp_w[c - 3]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    run      = 1'b1;
    momentum = 16'h0080;
    lr       = 16'h0040;
    load_default();

    // ---- Reset state, reset overrides run ----
    tick();
    tick();
    check("rst_raddr", 64'(raddr), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_we",    64'(we),    64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_wdw",   wdata_w,    64'd0);
    check("rst_wdv",   wdata_v,    64'd0);
    run = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // ---- Pass A: directed lane vectors at addresses 0..3 ----
    // momentum=0.5, lr=0.25
    set_exp_all(16'h0100, 16'h0200);
    // addr0 lane0: cancellation v=1.0 g=2.0 w=0x1234
    mem_v[0] = pack(16'h0100, 16'h0200, 16'h0200, 16'h0200);
    mem_g[0] = pack(16'h0200, 16'h0000, 16'h0000, 16'h0000);
    mem_w[0] = pack(16'h1234, 16'h0100, 16'h0100, 16'h0100);
    exp_v[0] = pack(16'h0000, 16'h0100, 16'h0100, 16'h0100);
    exp_w[0] = pack(16'h1234, 16'h0200, 16'h0200, 16'h0200);
    // addr1 lane0: overflow boundary w=0x7F00 v=0x0400
    mem_v[1] = pack(16'h0400, 16'h0200, 16'h0200, 16'h0200);
    mem_w[1] = pack(16'h7F00, 16'h0100, 16'h0100, 16'h0100);
    exp_v[1] = pack(16'h0200, 16'h0100, 16'h0100, 16'h0100);
`ifdef OPTIM_SAT_EN
    exp_w[1] = pack(16'h7FFF, 16'h0200, 16'h0200, 16'h0200);
`else
    exp_w[1] = pack(16'h8100, 16'h0200, 16'h0200, 16'h0200);
`endif
    // addr2 lane0: v=-1 lsb, g=0 -> mm=-1 lsb; lane1: v=g=-1 lsb, w=0x1000
    mem_v[2] = pack(16'hFFFF, 16'hFFFF, 16'h0200, 16'h0200);
    mem_g[2] = pack(16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    mem_w[2] = pack(16'h0000, 16'h1000, 16'h0100, 16'h0100);
    exp_v[2] = pack(16'hFFFF, 16'h0000, 16'h0100, 16'h0100);
    exp_w[2] = pack(16'hFFFF, 16'h1000, 16'h0200, 16'h0200);
    // addr3 lane0: v=g=1.0, w=0; lane1: v=g=-1.0, w=0x0040
    mem_v[3] = pack(16'h0100, 16'hFF00, 16'h0200, 16'h0200);
    mem_g[3] = pack(16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    mem_w[3] = pack(16'h0000, 16'h0040, 16'h0100, 16'h0100);
    exp_v[3] = pack(16'h0040, 16'hFFC0, 16'h0100, 16'h0100);
    exp_w[3] = pack(16'h0040, 16'h0000, 16'h0200, 16'h0200);
    run_pass("passA", 1'b0);

    // ---- Hold in DONE while run stays high ----
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("hold_valid_c%0d", c), 64'(valid), 64'd1);
      check($sformatf("hold_busy_c%0d", c),  64'(busy),  64'd0);
      check($sformatf("hold_we_c%0d", c),    64'(we),    64'd0);
    end
    run = 1'b0;
    tick();
    check("done_exit_valid", 64'(valid), 64'd0);

    // ---- Abort: run drops during cycle 4 of a pass ----
    load_default();
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("abt_raddr_c%0d", c), 64'(raddr), 64'(c));
    end
    check("abt_we_before", 64'(we), 64'd1);
    run = 1'b0;
    tick();
    check("abt_we",    64'(we),    64'd0);
    check("abt_busy",  64'(busy),  64'd0);
    check("abt_raddr", 64'(raddr), 64'd0);
    check("abt_valid", 64'(valid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("abt_quiet_we_c%0d", c), 64'(we), 64'd0);
    end

    // ---- Restart with new coefficients: momentum=1.0, lr=0 ----
    momentum = 16'h0100;
    lr       = 16'h0000;
    set_exp_all(16'h0200, 16'h0300);
    run_pass("passC", 1'b1);
    run = 1'b0;
    tick();

    // ---- Reset pulse mid-DRAIN ----
    momentum = 16'h0080;
    lr       = 16'h0040;
    run = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("drain_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    run = 1'b0;
    tick();
    check("mrst_raddr", 64'(raddr), 64'd0);
    check("mrst_waddr", 64'(waddr), 64'd0);
    check("mrst_we",    64'(we),    64'd0);
    check("mrst_busy",  64'(busy),  64'd0);
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_wdw",   wdata_w,    64'd0);
    check("mrst_wdv",   wdata_v,    64'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mrst_quiet_we_c%0d", c), 64'(we), 64'd0);
    end

    // ---- Fresh pass after reset restarts at address 0 ----
    set_exp_all(16'h0100, 16'h0200);
    run_pass("passD", 1'b0);
    run = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sgd_mtm_optim.md
SGD_MTM_OPTIM -- requirements
Module: sgd_mtm_optim

Interface
REQ-001 SHALL have parameter DATA_N, default 4: lanes (words) per memory beat.
REQ-002 SHALL have parameter N_LEN, default 16: signed fixed-point word width.
REQ-003 SHALL have parameter F_LEN, default 8: fraction bits, 0 < F_LEN < N_LEN.
REQ-004 SHALL have parameter DEPTH, default 8: beats per pass, >= 1.
REQ-005 SHALL have parameter ADDR_WIDTH, default 10: address width, 2^ADDR_WIDTH >= DEPTH.
REQ-006 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level request; high starts and holds a pass, low aborts or clears it.
- momentum  in  N_LEN  signed momentum coefficient.
- lr  in  N_LEN  signed learning rate.
- raddr  out  ADDR_WIDTH  read address to the w, v and grad memories.
- rdata_w, rdata_v, rdata_grad  in  DATA_N*N_LEN each  read data, valid 1 cycle after raddr; lane i at bits [i*N_LEN +: N_LEN].
- we  out  1  write enable for the w and v memories.
- waddr  out  ADDR_WIDTH  write address.
- wdata_w, wdata_v  out  DATA_N*N_LEN each  updated weight and velocity, same lane packing.
- busy  out  1  high in states READ and DRAIN.
- valid  out  1  high in state DONE.

Function
REQ-007 SHALL implement the FSM states IDLE, READ, DRAIN and DONE.
REQ-008 IDLE->READ when run=1; the same edge SHALL latch momentum and lr, which stay constant for the pass.
REQ-009 In READ, raddr SHALL step 0,1,...,DEPTH-1, one beat per cycle; after issuing DEPTH-1 the FSM SHALL go to DRAIN.
REQ-010 In DRAIN, raddr SHALL hold DEPTH-1; once the last beat is written the FSM SHALL go to DONE.
REQ-011 DONE SHALL persist while run=1, with no further reads or writes; DONE->IDLE when run=0.
REQ-012 In any state other than IDLE, run=0 SHALL force IDLE on the next edge:
- we=0 from that edge;
- in-flight beats discarded;
- raddr returns to 0.
REQ-013 Latency SHALL be fixed at 3 cycles: beat issued on raddr=a at cycle t gives we=1, waddr=a, wdata valid at cycle t+3.
REQ-014 we SHALL be high for exactly DEPTH cycles per completed pass, with waddr 0..DEPTH-1 consecutive and in order.
REQ-015 Per lane, with full signed 2*N_LEN products:
- mm = bits [F_LEN +: N_LEN] of momentum*v;
- ml = bits [F_LEN +: N_LEN] of lr*g;
- truncation toward minus infinity.
REQ-016 Per lane, wdata_v SHALL be v' = mm - ml and wdata_w SHALL be w' = w + v', using arithmetic per REQ-024/025.
REQ-017 Pipeline stage 1 SHALL register mm, ml and delayed w; stage 2 SHALL register v' and w' to the outputs.
REQ-018 For DEPTH=1, READ SHALL last one cycle, followed by DRAIN, then DONE.
REQ-019 raddr SHALL never exceed DEPTH-1.

Reset
REQ-020 rst=1 at a clock edge SHALL force state IDLE, overriding run.
REQ-021 Reset SHALL force raddr=0, waddr=0, we=0, busy=0, valid=0.
REQ-022 Reset SHALL clear wdata_w, wdata_v, all pipeline registers and the latched coefficients to 0.
REQ-023 Reset asserted mid-pass SHALL cause no further we pulses; the next pass SHALL restart at address 0.

Configuration
REQ-024 With macro OPTIM_SAT_EN defined:
- mm, ml, v' and w' SHALL each saturate to [-2^(N_LEN-1), 2^(N_LEN-1)-1] instead of wrapping;
- w' SHALL add the already-saturated v'.
REQ-025 With OPTIM_SAT_EN undefined, all arithmetic SHALL wrap modulo 2^N_LEN, so w' = w + mm - ml mod 2^N_LEN.

Verification (DATA_N=4, N_LEN=16, F_LEN=8, DEPTH=8, momentum=0x0080, lr=0x0040)
REQ-026 Cancellation: v=0x0100, g=0x0200, w=0x1234 -> v'=0x0000, w'=0x1234.
REQ-027 Full pass with g=0, v=0x0200, w=0x0100 at every address:
- we high for 8 cycles, 3 cycles after each raddr, waddr 0..7 in order;
- v'=0x0100, w'=0x0200 for every lane;
- then valid=1, busy=0.
REQ-028 Boundary: w=0x7F00, v=0x0400, g=0 -> w'=0x7FFF with OPTIM_SAT_EN, 0x8100 without.
REQ-029 Negative truncation: v=0xFFFF, g=0 -> mm=0xFFFF, v'=0xFFFF.
REQ-030 Abort: run drops at cycle 4 of a pass -> we=0 from the next edge, state IDLE; raising run again restarts at raddr=0 with freshly latched coefficients.
REQ-031 Reset and hold:
- rst pulse mid-DRAIN -> all outputs 0 next cycle, no further we;
- run held high after DONE -> valid stays 1 and no new pass starts.
